// File: rtl/mult_job_sequencer_pkg.sv
// Shared definitions for the multiplier job sequencer.
//   seq_state_t  : sequencer FSM encoding (IDLE/START/WAIT/HOLD)
//   ctrl_state_t : state codes reported by the multiplier control FSM
//   PROD_W       : product width
package mult_seq_pkg;

    localparam int PROD_W = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } seq_state_t;

    typedef enum logic [2:0] {
        IDLE_C      = 3'b000,
        LSB_C       = 3'b001,
        MID_C       = 3'b010,
        MSB_C       = 3'b011,
        CALC_DONE_C = 3'b100,
        ERR_C       = 3'b101
    } ctrl_state_t;

endpackage

// File: rtl/mult_job_sequencer_if.sv
// Bundle of the sequencer's job-side and multiplier-side signals.
//   slave  : the sequencer's view (drives in_ready, results, multiplier start/operands, busy)
//   master : the surrounding logic's view (drives jobs, out_ready, multiplier status)
interface mult_job_sequencer_if;
    import mult_seq_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_a;
    logic [7:0]        in_b;
    logic              out_valid;
    logic              out_ready;
    logic [PROD_W-1:0] out_product;
    logic              out_error;
    logic              mult_start;
    logic [7:0]        mult_dataa;
    logic [7:0]        mult_datab;
    logic              mult_done;
    logic [PROD_W-1:0] mult_product;
    logic [2:0]        mult_state;
    logic              busy;

    modport slave (
        input  in_valid, in_a, in_b, out_ready, mult_done, mult_product, mult_state,
        output in_ready, out_valid, out_product, out_error, mult_start,
               mult_dataa, mult_datab, busy
    );

    modport master (
        output in_valid, in_a, in_b, out_ready, mult_done, mult_product, mult_state,
        input  in_ready, out_valid, out_product, out_error, mult_start,
               mult_dataa, mult_datab, busy
    );

endinterface

// File: rtl/mult_seq_timer.sv
// 8-bit wait timer for the job sequencer.
//   clk, reset_a : clock, synchronous active-high reset
//   clr          : synchronous clear to 0 (wins over en)
//   en           : increment
//   tc           : count has reached TIMEOUT-1
module mult_seq_timer #(
    parameter int TIMEOUT = 8
) (
    input  logic clk,
    input  logic reset_a,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [7:0] TC_VAL = 8'(TIMEOUT - 1);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (reset_a || clr) begin
            count <= 8'd0;
        end else if (en) begin
            count <= count + 8'd1;
        end
    end

    assign tc = (count == TC_VAL);

endmodule

// File: rtl/mult_job_sequencer.sv
// Job front end for the 8x8 sequential multiplier: takes an operand pair,
// pulses mult_start once, holds operands while the multiply runs, then
// returns the product (or an error result on controller error / timeout).
//   clk, reset_a : clock, synchronous active-high reset (shared with controller)
//   bus          : job handshake, result handshake and multiplier control signals
//   TIMEOUT      : max WAIT cycles for mult_done (5..255)
module mult_job_sequencer
    import mult_seq_pkg::*;
#(
    parameter int TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 reset_a,
    mult_job_sequencer_if.slave  bus
);

    seq_state_t        state;
    logic [7:0]        op_a, op_b;
    logic [PROD_W-1:0] prod_r;
    logic              err_r;
    logic              out_valid_r;
    logic              start_r;
    logic              busy_r;

    logic              tmr_tc;
    logic              wait_fail;
    logic              tmr_en;

    // Controller error and timeout share one outcome; done takes priority.
    assign wait_fail = (bus.mult_state == ERR_C) || tmr_tc;
    assign tmr_en    = (state == S_WAIT) && !bus.mult_done && !wait_fail;

    mult_seq_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset_a (reset_a),
        .clr     (state == S_START),
        .en      (tmr_en),
        .tc      (tmr_tc)
    );

    // In HOLD a new pair is taken only together with the result handoff,
    // which lets back-to-back jobs skip the IDLE cycle.
    assign bus.in_ready = (state == S_IDLE) ||
                          ((state == S_HOLD) && bus.out_ready && bus.in_valid);

    always_ff @(posedge clk) begin
        if (reset_a) begin
            state       <= S_IDLE;
            op_a        <= 8'd0;
            op_b        <= 8'd0;
            prod_r      <= '0;
            err_r       <= 1'b0;
            out_valid_r <= 1'b0;
            start_r     <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        op_a    <= bus.in_a;
                        op_b    <= bus.in_b;
                        start_r <= 1'b1;
                        busy_r  <= 1'b1;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    start_r <= 1'b0;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.mult_done) begin
                        prod_r      <= bus.mult_product;
                        err_r       <= 1'b0;
                        out_valid_r <= 1'b1;
                        state       <= S_HOLD;
                    end else if (wait_fail) begin
                        prod_r      <= '0;
                        err_r       <= 1'b1;
                        out_valid_r <= 1'b1;
                        state       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        if (bus.in_valid) begin
                            op_a    <= bus.in_a;
                            op_b    <= bus.in_b;
                            start_r <= 1'b1;
                            state   <= S_START;
                        end else begin
                            busy_r <= 1'b0;
                            state  <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.out_valid   = out_valid_r;
    assign bus.out_product = prod_r;
    assign bus.out_error   = err_r;
    assign bus.mult_start  = start_r;
    assign bus.mult_dataa  = op_a;
    assign bus.mult_datab  = op_b;
    assign bus.busy        = busy_r;

endmodule

// File: tb/tb_mult_job_sequencer.sv
// Bench for mult_job_sequencer: directed timing/boundary steps followed by a
// randomized job stream checked against a queue of expected products. A
// small behavioural controller model answers mult_start.
module tb_mult_job_sequencer;
    import mult_seq_pkg::*;

    logic clk = 1'b0;
    logic reset_a = 1'b1;
    always #5 clk = ~clk;

    mult_job_sequencer_if bus();

    mult_job_sequencer #(.TIMEOUT(8)) dut (
        .clk     (clk),
        .reset_a (reset_a),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- controller model ----------------
    // Five busy states after start (lsb, mid, mid, msb, calc_done); done in calc_done.
    logic        mdl_active = 1'b0;
    int          mdl_cnt = 0;
    logic        mdl_err = 1'b0;
    logic [15:0] mdl_prod = 16'd0;
    logic        mode_err = 1'b0;
    logic        mode_nodone = 1'b0;
    logic        stray_done = 1'b0;
    logic        start_viol = 1'b0;
    logic        err_now;

    assign err_now = mode_err && mdl_active && (mdl_cnt == 1);

    always @(posedge clk) begin
        if (reset_a) begin
            mdl_active <= 1'b0;
            mdl_cnt    <= 0;
            mdl_err    <= 1'b0;
        end else if (bus.mult_start) begin
            if (mdl_active) start_viol <= 1'b1;
            mdl_active <= 1'b1;
            mdl_cnt    <= 0;
            mdl_err    <= 1'b0;
            mdl_prod   <= 16'(bus.mult_dataa) * 16'(bus.mult_datab);
        end else if (err_now) begin
            mdl_err    <= 1'b1;
            mdl_active <= 1'b0;
        end else if (mdl_active) begin
            mdl_cnt <= mdl_cnt + 1;
            if (mdl_cnt == 4) mdl_active <= 1'b0;
        end
    end

    assign bus.mult_done    = (mdl_active && mdl_cnt == 4 && !mode_nodone) || stray_done;
    assign bus.mult_product = mdl_prod;
    assign bus.mult_state   = (mdl_err || err_now) ? 3'b101 :
                              !mdl_active          ? 3'b000 :
                              (mdl_cnt == 0)       ? 3'b001 :
                              (mdl_cnt <= 2)       ? 3'b010 :
                              (mdl_cnt == 3)       ? 3'b011 : 3'b100;

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a pair in the current cycle; returns in cycle 1 of the job.
    task automatic issue(input logic [7:0] a, input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_a = a;
        bus.in_b = b;
        #1;
        chk("issue_in_ready", bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Called in cycle 1 after a handshake; returns the cycle out_valid is seen.
    task automatic wait_out(output int k);
        k = 1;
        while (!bus.out_valid && k < 40) begin
            tick();
            k++;
        end
    endtask

    int          lat;
    logic        seen;
    int          sent, got;
    logic [15:0] expq[$];
    logic [15:0] exp_p;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = 8'd0;
        bus.in_b      = 8'd0;
        bus.out_ready = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_busy",      bus.busy, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_start",     bus.mult_start, 1'b0);
        chk("rst_product",   bus.out_product, 16'd0);
        chk("rst_error",     bus.out_error, 1'b0);
        chk("rst_dataa",     bus.mult_dataa, 8'd0);
        reset_a = 1'b0;
        #1;
        chk("rst_in_ready",  bus.in_ready, 1'b1);

        // 13 x 11: start pulse in cycle 1 only, result in cycle 7
        issue(8'd13, 8'd11);
        chk("t1_start_c1", bus.mult_start, 1'b1);
        chk("t1_busy_c1",  bus.busy, 1'b1);
        tick();
        chk("t1_start_c2", bus.mult_start, 1'b0);
        chk("t1_dataa",    bus.mult_dataa, 8'd13);
        wait_out(lat);
        lat = lat + 1;  // wait_out started in cycle 2 here
        chk("t1_latency",  lat, 7);
        chk("t1_product",  bus.out_product, 16'd143);
        chk("t1_error",    bus.out_error, 1'b0);
        tick();
        chk("t1_idle_ov",  bus.out_valid, 1'b0);
        chk("t1_idle_bsy", bus.busy, 1'b0);

        // 255 x 255 with out_ready stalled 4 cycles
        bus.out_ready = 1'b0;
        issue(8'hFF, 8'hFF);
        wait_out(lat);
        chk("t2_latency", lat, 7);
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a = 8'd1;
            bus.in_b = 8'd2;
            #1;
            chk("t2_in_ready", bus.in_ready, 1'b0);
            chk("t2_hold_ov",  bus.out_valid, 1'b1);
            chk("t2_product",  bus.out_product, 16'hFE01);
            chk("t2_dataa",    bus.mult_dataa, 8'hFF);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        chk("t2_final_ov", bus.out_valid, 1'b1);
        tick();
        chk("t2_released", bus.out_valid, 1'b0);
        chk("t2_single",   bus.busy, 1'b0);
        chk("t2_datab",    bus.mult_datab, 8'hFF);

        // Back-to-back 3x5 then 200x2
        bus.in_valid = 1'b1;
        bus.in_a = 8'd3;
        bus.in_b = 8'd5;
        tick();
        bus.in_a = 8'd200;
        bus.in_b = 8'd2;
        wait_out(lat);
        chk("t3_lat1",     lat, 7);
        chk("t3_prod1",    bus.out_product, 16'd15);
        #1;
        chk("t3_in_ready", bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        chk("t3_nogap_start", bus.mult_start, 1'b1);
        chk("t3_nogap_busy",  bus.busy, 1'b1);
        wait_out(lat);
        chk("t3_lat2",     lat, 7);
        chk("t3_prod2",    bus.out_product, 16'd400);
        chk("t3_err2",     bus.out_error, 1'b0);
        tick();

        // Controller error in WAIT cycle 2, then a clean job
        mode_err = 1'b1;
        issue(8'd9, 8'd9);
        wait_out(lat);
        chk("t4_err_lat",  lat, 4);
        chk("t4_err_flag", bus.out_error, 1'b1);
        chk("t4_err_prod", bus.out_product, 16'd0);
        tick();
        mode_err = 1'b0;
        issue(8'd7, 8'd9);
        wait_out(lat);
        chk("t4_rec_lat",  lat, 7);
        chk("t4_rec_prod", bus.out_product, 16'd63);
        chk("t4_rec_err",  bus.out_error, 1'b0);
        tick();

        // Missing done: timeout result in cycle 10
        mode_nodone = 1'b1;
        issue(8'd5, 8'd5);
        wait_out(lat);
        chk("t5_to_lat",  lat, 10);
        chk("t5_to_err",  bus.out_error, 1'b1);
        chk("t5_to_prod", bus.out_product, 16'd0);
        tick();
        mode_nodone = 1'b0;
        stray_done = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.out_valid || bus.busy) seen = 1'b1;
        end
        stray_done = 1'b0;
        chk("t5_stray_done", seen, 1'b0);
        chk("t5_stray_err",  bus.out_error, 1'b1);

        // Reset in cycle 4 of a job
        issue(8'd6, 8'd7);
        tick();
        tick();
        tick();
        reset_a = 1'b1;
        tick();
        chk("t6_busy",  bus.busy, 1'b0);
        chk("t6_ready", bus.in_ready, 1'b1);
        chk("t6_ov",    bus.out_valid, 1'b0);
        chk("t6_start", bus.mult_start, 1'b0);
        reset_a = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.out_valid) seen = 1'b1;
        end
        chk("t6_no_result", seen, 1'b0);

        // Randomized job stream with random backpressure
        sent = 0;
        got = 0;
        for (int c = 0; c < 3000 && got < 25; c++) begin
            bus.in_valid  = (sent < 25) && ($urandom_range(2) != 0);
            bus.in_a      = 8'($urandom);
            bus.in_b      = 8'($urandom);
            bus.out_ready = ($urandom_range(1) != 0);
            #1;
            if (bus.out_valid && bus.out_ready) begin
                if (expq.size() == 0) begin
                    chk("rnd_spurious", 1'b1, 1'b0);
                end else begin
                    exp_p = expq.pop_front();
                    chk("rnd_product", bus.out_product, exp_p);
                    chk("rnd_error",   bus.out_error, 1'b0);
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                expq.push_back(16'(bus.in_a) * 16'(bus.in_b));
                sent++;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        chk("rnd_count", got, 25);
        chk("start_while_ctrl_busy", start_viol, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mult_job_sequencer.md
# mult_job_sequencer

Job-level front end for the 8x8 sequential multiplier. Accepts operand pairs on a valid/ready input, issues a one-cycle `start` pulse to the multiplier control FSM, and holds the operands stable while the multiply runs. It waits for `done`, captures the 16-bit product and returns it on a valid/ready output. It also detects a controller error state or a missing `done` and reports an error result.

## Interface
- `TIMEOUT`, default 8: maximum WAIT cycles allowed for `mult_done`; legal range 5..255.
- `clk` in 1: single clock; all logic on rising edge.
- `reset_a` in 1: reset, synchronous, active-high.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: sequencer accepts a pair this cycle.
- `in_a`, `in_b` in 8 each: unsigned operands.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts the result.
- `out_product` out 16: product, or 0 on error.
- `out_error` out 1: result is an error result.
- `mult_start` out 1: start to the multiplier control.
- `mult_dataa`, `mult_datab` out 8 each: operands to the multiplier datapath.
- `mult_done` in 1: done from the multiplier control.
- `mult_product` in 16: datapath product, valid while `mult_done`=1.
- `mult_state` in 3: controller `state_out`; 3'b101 means error.
- `busy` out 1: state is not IDLE.

## Operation
- FSM states: IDLE, START, WAIT, HOLD.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`, register `in_a`/`in_b` into the operand regs and go to START.
- START:
  - `mult_start`=1 for exactly one cycle.
  - Timer cleared to 0; go to WAIT.
- WAIT, evaluated in this priority order:
  - `mult_done`=1: capture `mult_product`, error=0, go to HOLD.
  - Else `mult_state`==3'b101 or timer==TIMEOUT-1: product=0, error=1, go to HOLD.
  - Else timer increments.
- HOLD:
  - `out_valid`=1.
  - On `out_ready`:
    - If `in_valid` is also high, accept the new pair (`in_ready`=1 in this case only) and go to START.
    - Otherwise go to IDLE.
- `mult_start` is never asserted outside START. `start` must be 0 through lsb..calc_done, or the controller falls into its error state.
- Error recovery: the next START pulse moves the controller from its error state to lsb, so no separate recovery sequence is needed.
- `mult_dataa`/`mult_datab` come from the operand regs. They change only on an input handshake and stay stable from START through HOLD.
- `out_product`/`out_error` are registered and change only on the WAIT→HOLD transition.
- A `mult_done` outside WAIT is ignored.
- Reset values: state=IDLE; operand regs, `out_product`, `out_error`, timer = 0; `out_valid`=0, `mult_start`=0, `busy`=0. `in_ready`=1 from the first cycle after reset.
- A reset mid-operation abandons the job with no output. The controller shares `reset_a` through the top, so both return to idle.

## Timing
- Cycle 0: input handshake.
- Cycle 1: START, `mult_start`=1.
- Cycles 2..6: controller states lsb (count 0), mid (count 1), mid (count 2), msb (count 3), calc_done.
- `mult_done` is high in cycle 6. `out_valid` rises in cycle 7.
- Latency from input handshake to `out_valid` is 7 cycles.
- With `out_ready` held at 1 and `in_valid` continuous, throughput is one job per 7 cycles; the HOLD→START bypass saves the IDLE cycle.
- Timeout fires in WAIT cycle TIMEOUT, i.e. cycle TIMEOUT+1 after the handshake. The error result appears the following cycle.
- `out_valid` stays high, with stable data, until `out_ready`.

## Structure
- Package `mult_seq_pkg` holds:
  - the sequencer state encoding (2-bit: IDLE=0, START=1, WAIT=2, HOLD=3);
  - the controller state codes (IDLE_C=3'b000 .. ERR_C=3'b101);
  - the product width constant, 16.
- One sub-module, `mult_seq_timer`: 8-bit counter with sync clear, enable and terminal-count output at TIMEOUT-1.

## Test plan
- Reset then a=8'd13, b=8'd11 with a controller model → `mult_start` is a one-cycle pulse in cycle 1; `out_valid` in cycle 7 with `out_product`=16'd143 and `out_error`=0.
- a=8'hFF, b=8'hFF, with `out_ready` held at 0 for 4 cycles after `out_valid` → product 16'hFE01 held stable; `in_ready`=0 throughout; single acceptance.
- Back-to-back jobs (3×5, then 200×2) with `in_valid` and `out_ready` tied high → results 15 and 400 exactly 7 cycles apart; no IDLE cycle between them.
- Controller model forced to `mult_state`=3'b101 in WAIT cycle 2 → next cycle `out_valid`=1, `out_error`=1, `out_product`=0. The next job then completes correctly.
- `mult_done` never asserted, TIMEOUT=8 → `out_error`=1 with `out_valid` in cycle 10. A stray `mult_done` in IDLE is ignored.
- `reset_a`=1 in cycle 4 of a job → next cycle `busy`=0, `in_ready`=1, `out_valid`=0, `mult_start`=0; no result emitted.
